lfsr_checker: RTL

//  Downstream consumer of the 8-bit Galois LFSR (poly x^8+x^4+x^3+x^2+1, taps 0x1D).
//  - Self-synchronises to the incoming pattern and declares lock.
//  - After lock, free-runs its own reference and counts every mismatching byte.
//  - Sits on the LFSR data_out path; used as a link/BIST pattern checker.

---
 rtl/lfsr_checker.sv | 139 +++++++++++++
 1 files changed

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 8-bit Galois LFSR pattern (poly 0x1D): locks, then counts errors.
// Define LFSR_CHK_STICKY_EN to add the o_err_sticky output.
module lfsr_checker #(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 3,
    parameter int unsigned ERR_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_res_n,
    input  logic [7:0]       i_data_in,
    input  logic             i_valid_in,
    input  logic             i_err_clr,
    output logic             o_locked,
    output logic             o_err_pulse,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic [7:0]       o_expected
`ifdef LFSR_CHK_STICKY_EN
    ,
    output logic             o_err_sticky
`endif
);

    localparam int unsigned MCW = $clog2(LOCK_CNT + 1);
    localparam int unsigned LCW = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {StHunt, StSync, StLocked} state_e;

    state_e           r_state, w_state_d;
    logic [7:0]       r_ref, w_ref_d;
    logic [MCW-1:0]   r_match_cnt, w_match_cnt_d, w_match_inc;
    logic [LCW-1:0]   r_miss_cnt, w_miss_cnt_d, w_miss_inc;
    logic [ERR_W-1:0] r_err_cnt, w_err_cnt_d;
    logic             r_err_pulse;
    logic             w_err_evt;

    function automatic logic [7:0] lfsr_next(input logic [7:0] d);
        return {d[6], d[5], d[4], d[3] ^ d[7], d[2] ^ d[7], d[1] ^ d[7], d[0], d[7]};
    endfunction

    assign w_match_inc = r_match_cnt + MCW'(1);
    assign w_miss_inc  = r_miss_cnt + LCW'(1);

    always_comb begin
        w_state_d     = r_state;
        w_ref_d       = r_ref;
        w_match_cnt_d = r_match_cnt;
        w_miss_cnt_d  = r_miss_cnt;
        w_err_evt     = 1'b0;
        if (i_valid_in) begin
            unique case (r_state)
                StHunt: begin
                    // 0x00 is the LFSR lock-up value and can never seed a valid sequence
                    if (i_data_in != 8'h00) begin
                        w_ref_d       = lfsr_next(i_data_in);
                        w_match_cnt_d = '0;
                        w_state_d     = StSync;
                    end
                end
                StSync: begin
                    if (i_data_in == r_ref) begin
                        w_ref_d       = lfsr_next(i_data_in);
                        w_match_cnt_d = w_match_inc;
                        if (w_match_inc == MCW'(LOCK_CNT)) begin
                            w_state_d    = StLocked;
                            w_miss_cnt_d = '0;
                        end
                    end else if (i_data_in != 8'h00) begin
                        w_ref_d       = lfsr_next(i_data_in);
                        w_match_cnt_d = '0;
                    end else begin
                        w_state_d = StHunt;
                    end
                end
                StLocked: begin
                    w_ref_d = lfsr_next(r_ref);
                    if (i_data_in == r_ref) begin
                        w_miss_cnt_d = '0;
                    end else begin
                        w_err_evt = 1'b1;
                        if (w_miss_inc == LCW'(LOSS_CNT)) begin
                            w_state_d    = StHunt;
                            w_miss_cnt_d = '0;
                        end else begin
                            w_miss_cnt_d = w_miss_inc;
                        end
                    end
                end
                default: w_state_d = StHunt;
            endcase
        end

        w_err_cnt_d = r_err_cnt;
        if (i_err_clr) begin
            w_err_cnt_d = w_err_evt ? ERR_W'(1) : '0;
        end else if (w_err_evt && (r_err_cnt != {ERR_W{1'b1}})) begin
            w_err_cnt_d = r_err_cnt + ERR_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            r_state     <= StHunt;
            r_ref       <= 8'h00;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_err_cnt   <= '0;
            r_err_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_ref       <= w_ref_d;
            r_match_cnt <= w_match_cnt_d;
            r_miss_cnt  <= w_miss_cnt_d;
            r_err_cnt   <= w_err_cnt_d;
            r_err_pulse <= w_err_evt;
        end
    end

    assign o_locked    = (r_state == StLocked);
    assign o_err_pulse = r_err_pulse;
    assign o_err_cnt   = r_err_cnt;
    assign o_expected  = r_ref;

`ifdef LFSR_CHK_STICKY_EN
    logic r_err_sticky;

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            r_err_sticky <= 1'b0;
        end else if (i_err_clr) begin
            r_err_sticky <= w_err_evt;
        end else if (w_err_evt) begin
            r_err_sticky <= 1'b1;
        end
    end

    assign o_err_sticky = r_err_sticky;
`endif

endmodule
